// File: rtl/rng_pair_server_if.sv
// rtl/rng_pair_server_if.sv - PRNG word stream in, paired rng_1/rng_2 burst out
interface rng_pair_server_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_ready;
  logic          req;
  logic          busy;
  logic          rng_1_valid;
  logic          rng_2_valid;
  logic [63:0]   rng_1;
  logic [63:0]   rng_2;
  logic          burst_done;
  logic [LW-1:0] level;

  modport master (
    output in_valid, in_data, req,
    input  in_ready, busy, rng_1_valid, rng_2_valid, rng_1, rng_2, burst_done, level
  );

  modport slave (
    input  in_valid, in_data, req,
    output in_ready, busy, rng_1_valid, rng_2_valid, rng_1, rng_2, burst_done, level
  );
endinterface

// File: rtl/rng_pair_server.sv
// rtl/rng_pair_server.sv - FIFO of PRNG words served as gap-free alternating rng_1/rng_2 bursts
module rng_pair_server #(
  parameter int LOGN      = 9,
  parameter int DEPTH     = 8,
  parameter int BYTE_SWAP = 1
) (
  input logic              clk,
  input logic              rst_n,
  rng_pair_server_if.slave bus
);
  localparam int W  = 2 * (1 << (10 - LOGN));
  localparam int IW = $clog2(W) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] W_C     = CW'(W);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_C  = IW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [63:0]     mem_q [DEPTH];
  logic [63:0]     wdata, rdata;
  logic [63:0]     rng_1_q, rng_1_d, rng_2_q, rng_2_d;
  logic            v1_q, v1_d, v2_q, v2_d, done_q, done_d;
  logic            push, pop, enough, start, last;

  always_comb begin
    wdata = bus.in_data;
    if (BYTE_SWAP != 0) begin
      for (int i = 0; i < 8; i++) wdata[8*i +: 8] = bus.in_data[56-8*i +: 8];
    end
  end

  assign bus.in_ready = count_q < DEPTH_C;
  assign push         = bus.in_valid & bus.in_ready;
  assign enough       = count_q >= W_C;
  assign rdata        = mem_q[rd_ptr_q];
  assign last         = idx_q == LAST_C;
  assign start        = ((state_q == S_IDLE) & bus.req & enough) | ((state_q == S_WAIT) & enough);
  assign count_d      = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req) state_d = enough ? S_BURST : S_WAIT;
      S_WAIT:  if (enough) state_d = S_BURST;
      S_BURST: if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // idx_q is the index of the word popped in the current BURST cycle; word 0 leaves on entry.
  always_comb begin
    pop     = 1'b0;
    idx_d   = idx_q;
    v1_d    = 1'b0;
    v2_d    = 1'b0;
    done_d  = 1'b0;
    rng_1_d = rng_1_q;
    rng_2_d = rng_2_q;
    if (start) begin
      pop     = 1'b1;
      idx_d   = IW'(1);
      v1_d    = 1'b1;
      rng_1_d = rdata;
    end else if (state_q == S_BURST) begin
      pop    = 1'b1;
      idx_d  = last ? '0 : idx_q + 1'b1;
      done_d = last;
      if (idx_q[0]) begin
        v2_d    = 1'b1;
        rng_2_d = rdata;
      end else begin
        v1_d    = 1'b1;
        rng_1_d = rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      rng_1_q  <= '0;
      rng_2_q  <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      idx_q   <= idx_d;
      rng_1_q <= rng_1_d;
      rng_2_q <= rng_2_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // The FSM is already IDLE while the last word is on the outputs; busy still covers that cycle.
  assign bus.busy        = (state_q != S_IDLE) | done_q;
  assign bus.rng_1_valid = v1_q;
  assign bus.rng_2_valid = v2_q;
  assign bus.rng_1       = rng_1_q;
  assign bus.rng_2       = rng_2_q;
  assign bus.burst_done  = done_q;
  assign bus.level       = count_q;
endmodule

// File: tb/tb_rng_pair_server.sv
// tb/tb_rng_pair_server.sv - directed scoreboard bench for rng_pair_server
module tb_rng_pair_server;
  localparam int LOGN  = 9;
  localparam int DEPTH = 8;
  localparam int W     = 4;

  logic clk = 1'b0;
  logic rst_n;

  rng_pair_server_if #(.DEPTH(DEPTH)) bus();

  rng_pair_server #(.LOGN(LOGN), .DEPTH(DEPTH), .BYTE_SWAP(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  logic [63:0] sb[$];
  int          widx   = 0;
  int          vcount = 0;
  int          dcount = 0;
  logic [63:0] last1  = '0;
  logic [63:0] last2  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] swap(input logic [63:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40], d[55:48], d[63:56]};
  endfunction

  task automatic monitor();
    logic        any;
    logic [63:0] e;
    any = bus.rng_1_valid | bus.rng_2_valid;
    chk("both_valid", 64'(bus.rng_1_valid & bus.rng_2_valid), 64'd0);
    chk("burst_done", 64'(bus.burst_done), 64'(any && widx == W - 1));
    if (!bus.rng_1_valid) chk("rng_1_hold", bus.rng_1, last1);
    if (!bus.rng_2_valid) chk("rng_2_hold", bus.rng_2, last2);
    if (any) begin
      vcount++;
      chk("parity", 64'(bus.rng_2_valid), 64'(widx % 2));
      chk("sb_underflow", 64'(sb.size() == 0), 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (bus.rng_1_valid) chk("rng_1_word", bus.rng_1, e);
        else                 chk("rng_2_word", bus.rng_2, e);
      end
      if (bus.rng_1_valid) last1 = bus.rng_1;
      if (bus.rng_2_valid) last2 = bus.rng_2;
      if (bus.burst_done) dcount++;
      widx = (widx + 1) % W;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (rst_n) monitor();
  endtask

  task automatic push(input logic [63:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (bus.in_ready) sb.push_back(swap(d));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_req();
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pushed;
    int nreq;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.req      = 1'b0;
    tick();
    tick();
    chk("rst_v1", 64'(bus.rng_1_valid), 64'd0);
    chk("rst_v2", 64'(bus.rng_2_valid), 64'd0);
    chk("rst_done", 64'(bus.burst_done), 64'd0);
    chk("rst_rng_1", bus.rng_1, 64'd0);
    chk("rst_rng_2", bus.rng_2, 64'd0);
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Fill and burst
    push(64'h1111111111111111);
    push(64'h2222222222222222);
    push(64'h3333333333333333);
    push(64'h4444444444444444);
    chk("a_level_full", 64'(bus.level), 64'd4);
    vcount = 0;
    pulse_req();
    chk("a_v1_c1", 64'(bus.rng_1_valid), 64'd1);
    chk("a_rng_1_c1", bus.rng_1, 64'h1111111111111111);
    chk("a_busy_c1", 64'(bus.busy), 64'd1);
    tick();
    chk("a_rng_2_c2", bus.rng_2, 64'h2222222222222222);
    tick();
    chk("a_rng_1_c3", bus.rng_1, 64'h3333333333333333);
    tick();
    chk("a_rng_2_c4", bus.rng_2, 64'h4444444444444444);
    chk("a_done_c4", 64'(bus.burst_done), 64'd1);
    chk("a_busy_c4", 64'(bus.busy), 64'd1);
    tick();
    chk("a_busy_c5", 64'(bus.busy), 64'd0);
    chk("a_level_c5", 64'(bus.level), 64'd0);
    chk("a_vcount", 64'(vcount), 64'd4);

    // Byte swap
    push(64'h0102030405060708);
    push(64'h1020304050607080);
    push(64'hA1B2C3D4E5F60718);
    push(64'hDEADBEEFCAFEF00D);
    vcount = 0;
    pulse_req();
    chk("b_swap", bus.rng_1, 64'h0807060504030201);
    repeat (4) tick();
    chk("b_vcount", 64'(vcount), 64'd4);

    // Starved request
    vcount = 0;
    push(64'h5555000000000001);
    push(64'h5555000000000002);
    pulse_req();
    chk("c_busy", 64'(bus.busy), 64'd1);
    tick();
    tick();
    chk("c_no_valid", 64'(vcount), 64'd0);
    chk("c_busy_wait", 64'(bus.busy), 64'd1);
    push(64'h5555000000000003);
    chk("c_level3", 64'(bus.level), 64'd3);
    push(64'h5555000000000004);
    chk("c_level4", 64'(bus.level), 64'd4);
    chk("c_v1_d", 64'(bus.rng_1_valid), 64'd0);
    tick();
    chk("c_v1_d1", 64'(bus.rng_1_valid), 64'd1);
    repeat (4) tick();
    chk("c_vcount", 64'(vcount), 64'd4);
    chk("c_busy_end", 64'(bus.busy), 64'd0);

    // Backpressure and pointer wrap
    vcount = 0;
    dcount = 0;
    for (int i = 0; i < 8; i++) push({8'(i), 56'h13579BDF02468A});
    chk("d_level_full", 64'(bus.level), 64'd8);
    chk("d_in_ready_full", 64'(bus.in_ready), 64'd0);
    push(64'hFFFFFFFFFFFFFFFF);
    chk("d_level_after_9th", 64'(bus.level), 64'd8);
    pushed = 0;
    nreq   = 0;
    for (int i = 0; i < 200 && dcount < 4; i++) begin
      if (!bus.busy && nreq < 4) begin
        bus.req = 1'b1;
        nreq++;
      end else begin
        bus.req = 1'b0;
      end
      if (pushed < 8) begin
        bus.in_valid = 1'b1;
        bus.in_data  = {8'(pushed + 8), 56'hEC6A4E2C9B7F31};
        if (bus.in_ready) begin
          sb.push_back(swap(bus.in_data));
          pushed++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
    end
    bus.req      = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("d_bursts", 64'(dcount), 64'd4);
    chk("d_vcount", 64'(vcount), 64'd16);
    chk("d_sb_empty", 64'(sb.size()), 64'd0);
    chk("d_level_end", 64'(bus.level), 64'd0);

    // Ignored req mid-burst
    vcount = 0;
    for (int i = 0; i < 4; i++) push({32'h77770000, 32'(i)});
    pulse_req();
    tick();
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    tick();
    chk("e_busy_c5", 64'(bus.busy), 64'd0);
    chk("e_vcount", 64'(vcount), 64'd4);
    tick();
    tick();
    chk("e_vcount_after", 64'(vcount), 64'd4);
    chk("e_level", 64'(bus.level), 64'd0);

    // Reset mid-burst
    for (int i = 0; i < 4; i++) push({32'h99990000, 32'(i)});
    pulse_req();
    tick();
    rst_n = 1'b0;
    sb.delete();
    widx  = 0;
    last1 = '0;
    last2 = '0;
    tick();
    chk("f_v1", 64'(bus.rng_1_valid), 64'd0);
    chk("f_v2", 64'(bus.rng_2_valid), 64'd0);
    chk("f_done", 64'(bus.burst_done), 64'd0);
    chk("f_level", 64'(bus.level), 64'd0);
    chk("f_busy", 64'(bus.busy), 64'd0);
    chk("f_in_ready", 64'(bus.in_ready), 64'd1);
    chk("f_rng_1", bus.rng_1, 64'd0);
    rst_n = 1'b1;
    tick();
    vcount = 0;
    for (int i = 0; i < 4; i++) push({32'hBBBB0000, 32'(i + 5)});
    pulse_req();
    repeat (5) tick();
    chk("f_recover_vcount", 64'(vcount), 64'd4);
    chk("f_recover_sb", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
